// File: rtl/tvm_buffer_wr_arbiter.sv
// tvm_buffer_wr_arbiter: round-robin, burst-granular sharing of one tvm_buffer write port (FIFO mode).
// Latency: owner valid/data/ready pass straight through (zero cycles); each grant costs one registered IDLE cycle.
// Backpressure: buf_write_ready is routed only to the owner's req_ready; every non-owner sees ready=0.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   req_valid/req_last/req_data   per-producer write requests (producer i uses data slice i)
//   req_ready                     per-producer accept (only the owner can see it high)
//   buf_write_*                   buffer write port (valid, advance, addr=0, data, ready)
//   grant, busy, burst_count      one-hot owner, in-burst flag, words accepted in this burst
module tvm_buffer_wr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int WR_ADDR_WIDTH    = 1,
    parameter int MAX_BURST        = 8,
    parameter int BURST_CNTR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          buf_write_valid,
    output logic                          buf_write_advance,
    output logic [WR_ADDR_WIDTH-1:0]      buf_write_addr,
    output logic [DATA_WIDTH-1:0]         buf_write_data,
    input  logic                          buf_write_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [BURST_CNTR_WIDTH-1:0]   burst_count
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Counter value at which the word being accepted is the last one allowed in the burst.
    localparam logic [BURST_CNTR_WIDTH-1:0] LAST_CNT = BURST_CNTR_WIDTH'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;      // binary index of the granted producer
    logic [IDX_W-1:0]     rr_ptr;     // last producer served; search starts just above it
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 in_burst;
    logic                 owner_valid;
    logic                 xfer;
    logic                 release_now;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first requester strictly after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : arb_search
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign in_burst    = (state == BURST);
    assign owner_valid = in_burst & req_valid[owner];
    assign xfer        = owner_valid & buf_write_ready;
    assign release_now = xfer & (req_last[owner] | (burst_count == LAST_CNT));

    // Pass-through for the owner; everything reads as zero while IDLE.
    assign buf_write_valid   = owner_valid;
    assign buf_write_advance = owner_valid;
    assign buf_write_addr    = '0;
    assign buf_write_data    = in_burst ? data_arr[owner] : '0;
    assign busy              = in_burst;

    always_comb begin
        req_ready = '0;
        if (in_burst) begin
            req_ready[owner] = buf_write_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            burst_count <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= BURST;
                        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        owner <= win_idx;
                    end
                end
                BURST: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= '0;
                        burst_count <= '0;
                        rr_ptr      <= owner;
                    end else if (xfer) begin
                        burst_count <= burst_count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tvm_buffer_wr_arbiter.sv
// tb_tvm_buffer_wr_arbiter: directed and randomized checks of the write-port arbiter.
// Latency: producers are queue-backed; every cycle compares all outputs to a reference model.
// Backpressure: buf_write_ready and per-producer valid enables are driven directly by the bench.
`timescale 1ns/1ps
module tb_tvm_buffer_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int MB = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              buf_write_valid;
    logic              buf_write_advance;
    logic [AW-1:0]     buf_write_addr;
    logic [DW-1:0]     buf_write_data;
    logic              buf_write_ready;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [CW-1:0]     burst_count;

    always #5 clk = ~clk;

    tvm_buffer_wr_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .WR_ADDR_WIDTH(AW),
        .MAX_BURST(MB), .BURST_CNTR_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .buf_write_valid(buf_write_valid), .buf_write_advance(buf_write_advance),
        .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
        .buf_write_ready(buf_write_ready),
        .grant(grant), .busy(busy), .burst_count(burst_count)
    );

    int checks = 0;
    int fails  = 0;

    // Producer word queues: {last, data}
    logic [8:0] pmem [NR][256];
    int         phead [NR];
    int         ptail [NR];
    logic [NR-1:0] en;

    // Reference model: who owns the port, how many words it has sent, who was served last
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_last;

    // Observations taken from the DUT, compared against literal expectations
    logic [7:0] word_log [$];
    logic [7:0] cnt_log [$];
    logic [7:0] grant_log [$];
    logic [7:0] exp_q [$];
    logic [NR-1:0] prev_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int which);
        logic [7:0] got [$];
        if (which == 0) got = word_log;
        else if (which == 1) got = cnt_log;
        else got = grant_log;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            chk(tag, got[k], exp_q[k]);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input bit last);
        pmem[p][ptail[p]] = {last, d};
        ptail[p]++;
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = NR - 1;
        prev_grant = '0;
        for (int i = 0; i < NR; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
            for (int j = 0; j < 256; j++) pmem[i][j] = '0;
        end
        word_log.delete();
        cnt_log.delete();
        grant_log.delete();
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NR; i++) if (phead[i] != ptail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cnt"}, burst_count, 0);
        chk({tag, "_valid"}, buf_write_valid, 0);
        chk({tag, "_data"}, buf_write_data, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    // One clock cycle: drive from queues, check against model at negedge+1, advance model.
    task automatic tick();
        logic [NR-1:0] exp_rdy;
        bit mval;
        int c;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (phead[i] < ptail[i]) && en[i];
            req_data[i*DW +: DW]  = pmem[i][phead[i]][7:0];
            req_last[i]           = pmem[i][phead[i]][8];
        end
        #1;
        mval    = m_busy && req_valid[m_owner];
        exp_rdy = m_busy ? (NR'(buf_write_ready) << m_owner) : '0;
        chk("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("busy", busy, m_busy);
        chk("burst_count", burst_count, m_cnt);
        chk("wr_valid", buf_write_valid, mval);
        chk("wr_advance", buf_write_advance, mval);
        chk("wr_data", buf_write_data, m_busy ? pmem[m_owner][phead[m_owner]][7:0] : 8'h00);
        chk("req_ready", req_ready, exp_rdy);
        chk("wr_addr", buf_write_addr, 0);

        if (grant != 0 && prev_grant == 0) grant_log.push_back(8'(grant));
        prev_grant = grant;
        if (buf_write_valid && buf_write_ready) begin
            word_log.push_back(buf_write_data);
            cnt_log.push_back(8'(burst_count));
        end

        if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!m_busy && req_valid[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                end
            end
        end else if (mval && buf_write_ready) begin
            if (req_last[m_owner] || m_cnt == MB - 1) begin
                m_busy = 1'b0;
                m_cnt  = 0;
                m_last = m_owner;
            end else begin
                m_cnt++;
            end
            phead[m_owner]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        model_reset();
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!(all_empty() && !m_busy) && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, (all_empty() && !m_busy), 1);
        tick();
    endtask

    initial begin
        int next_seq [NR];
        logic [7:0] w;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        buf_write_ready = 1'b1;
        en = '1;
        @(negedge clk);

        // Single producer, three-word burst
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        repeat (4) tick();
        chk("t1_grant_released", grant, 0);
        chk("t1_busy_released", busy, 0);
        tick();
        exp_q.delete(); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        chk_q("t1_words", 0);
        exp_q.delete(); exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        chk_q("t1_counts", 1);

        // All four requesting single-word bursts: rotation from producer 0
        do_reset();
        for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1);
        push(0, 8'hB0, 1);
        run_until_idle("t2", 60);
        exp_q.delete();
        exp_q.push_back(8'h1); exp_q.push_back(8'h2); exp_q.push_back(8'h4);
        exp_q.push_back(8'h8); exp_q.push_back(8'h1);
        chk_q("t2_grant_order", 2);
        exp_q.delete();
        for (int i = 0; i < NR; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'hB0);
        chk_q("t2_words", 0);

        // Producer 2 streams 20 words without last: forced releases at MAX_BURST
        do_reset();
        for (int k = 0; k < 20; k++) push(2, 8'h40 + 8'(k), 0);
        repeat (26) tick();
        chk("t3_hold_grant", grant, 4);
        chk("t3_hold_cnt", burst_count, 4);
        push(2, 8'h54, 1);
        run_until_idle("t3", 20);
        exp_q.delete();
        for (int k = 0; k < 21; k++) exp_q.push_back(8'h40 + 8'(k));
        chk_q("t3_words", 0);
        exp_q.delete();
        for (int k = 0; k < 21; k++) exp_q.push_back(8'(k % MB));
        chk_q("t3_counts", 1);
        exp_q.delete(); exp_q.push_back(8'h4); exp_q.push_back(8'h4); exp_q.push_back(8'h4);
        chk_q("t3_grants", 2);

        // Buffer full for 5 cycles mid-burst
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 8'h70 + 8'(k), k == 5);
        repeat (3) tick();
        buf_write_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("t4_cnt_stable", burst_count, 2);
            chk("t4_data_stable", buf_write_data, 8'h72);
            chk("t4_ready_low", req_ready, 0);
        end
        buf_write_ready = 1'b1;
        run_until_idle("t4", 20);
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h70 + 8'(k));
        chk_q("t4_words", 0);

        // Owner drops valid for 3 cycles while producer 1 waits
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 8'h80 + 8'(k), k == 3);
        push(1, 8'h90, 1);
        repeat (2) tick();
        en[0] = 1'b0;
        repeat (3) begin
            tick();
            chk("t5_grant_held", grant, 1);
            chk("t5_valid_low", buf_write_valid, 0);
        end
        en = '1;
        run_until_idle("t5", 20);
        exp_q.delete(); exp_q.push_back(8'h1); exp_q.push_back(8'h2);
        chk_q("t5_grants", 2);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h80 + 8'(k));
        exp_q.push_back(8'h90);
        chk_q("t5_words", 0);

        // Asynchronous reset between clock edges, mid-burst
        do_reset();
        for (int k = 0; k < 6; k++) push(3, 8'hC0 + 8'(k), 0);
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        chk_idle_outputs("t6_async");
        model_reset();
        #4 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) push(i, 8'hD0 + 8'(i), 1);
        run_until_idle("t6", 40);
        exp_q.delete();
        exp_q.push_back(8'h1); exp_q.push_back(8'h2); exp_q.push_back(8'h4); exp_q.push_back(8'h8);
        chk_q("t6_grants", 2);

        // Randomized traffic: random enables, last markers and buffer backpressure
        do_reset();
        for (int i = 0; i < NR; i++) begin
            next_seq[i] = 0;
            for (int s = 0; s < 30; s++)
                push(i, {2'(i), 6'(s)}, (s == 29) || ($urandom % 4 == 0));
        end
        for (int n = 0; n < 4000 && !(all_empty() && !m_busy); n++) begin
            for (int i = 0; i < NR; i++) en[i] = ($urandom % 4) != 0;
            buf_write_ready = ($urandom % 4) != 0;
            tick();
        end
        en = '1;
        buf_write_ready = 1'b1;
        chk("rand_drained", (all_empty() && !m_busy), 1);
        chk("rand_word_total", word_log.size(), NR * 30);
        foreach (word_log[k]) begin
            w = word_log[k];
            chk("rand_order", w[5:0], next_seq[w[7:6]]);
            next_seq[w[7:6]]++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/tvm_buffer_wr_arbiter.md
Name: tvm_buffer_wr_arbiter

Overview:
Shares the single write port of one tvm_buffer instance, in FIFO mode, among NUM_REQ producers.
- Arbitration is round-robin at burst granularity.
- A granted producer owns the port until it signals last or reaches MAX_BURST words.
- The block drives write_valid, write_advance, write_addr and write_data of the buffer and consumes its write_ready.

Parameters:
NUM_REQ, 4, number of producers (2..16)
DATA_WIDTH, 8, word width; must match the buffer DATA_WIDTH
WR_ADDR_WIDTH, 1, width of the buffer write_addr
MAX_BURST, 8, maximum words per grant (1..2^BURST_CNTR_WIDTH)
BURST_CNTR_WIDTH, 4, width of the burst counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  per-producer word valid
req_last  input  NUM_REQ  per-producer end-of-burst marker, qualified by req_valid
req_data  input  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-producer accept
buf_write_valid  output  1  to buffer write_valid
buf_write_advance  output  1  to buffer write_advance
buf_write_addr  output  WR_ADDR_WIDTH  to buffer write_addr; constant 0
buf_write_data  output  DATA_WIDTH  to buffer write_data
buf_write_ready  input  1  from buffer write_ready
grant  output  NUM_REQ  one-hot current owner; 0 when idle
busy  output  1  high in BURST
burst_count  output  BURST_CNTR_WIDTH  words accepted in the current burst

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On rst: state=IDLE, grant=0, burst_count=0, rr_ptr=NUM_REQ-1, so producer 0 has top priority after reset.
  - All outputs are combinationally 0 while in IDLE, including buf_write_data.
  - Reset asserted mid-burst aborts the burst. Words already accepted stay in the buffer; there is no rollback.
- FSM states: IDLE, BURST.
- IDLE: if any req_valid is set, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Registered: grant<=onehot(winner), state<=BURST.
  - No transfer occurs in IDLE; req_ready=0 there.
- BURST, with g the owner (purely combinational pass-through, zero added latency):
  - buf_write_valid = buf_write_advance = req_valid[g]
  - buf_write_data = req_data[g]
  - req_ready[g] = buf_write_ready; all other req_ready = 0
- Transfer: xfer = buf_write_valid & buf_write_ready. On xfer, burst_count increments.
- Release: on xfer with req_last[g]=1, or with burst_count==MAX_BURST-1:
  - state<=IDLE, grant<=0, burst_count<=0, rr_ptr<=g.
  - Exactly one IDLE bubble cycle occurs between bursts. This is deliberate: the arbitration decision is fully registered.
- Owner drops req_valid mid-burst: the grant is held with no timeout, and buf_write_valid=0. Other requesters wait.
- Buffer full (buf_write_ready=0): no xfer, burst_count holds, state holds. The producer must hold data and last stable while valid & !ready.
- req_valid of non-owners is ignored during BURST; they are not starved. Worst-case wait is (NUM_REQ-1) bursts plus bubbles.
- MAX_BURST=1: every word is a separate grant.
- burst_count never exceeds MAX_BURST-1 at a clock edge, so no wrap.
- busy = (state==BURST). grant is one-hot or zero at all times.

Test Plan:
- Reset then req_valid=4'b0001, 3 words 0x11,0x22,0x33 with last on 0x33, buf_write_ready=1 -> grant=0001 the cycle after the request; three consecutive xfers; burst_count goes 0,1,2; grant=0 and busy=0 the cycle after 0x33.
- req_valid=4'b1111 held, each producer sends 1-word bursts with last=1 -> grant order 0001,0010,0100,1000,0001; one idle cycle between each grant.
- Producer 2 streams 20 words with no last, MAX_BURST=8 -> forced releases after words 8 and 16; since only producer 2 requests, it regains the grant each time; buf_write_data order is unchanged.
- Owner active and buf_write_ready low for 5 cycles mid-burst -> no xfer, req_ready[g]=0, burst_count and buf_write_data stable; resumes on ready with no lost or duplicated word.
- Owner deasserts req_valid for 3 cycles mid-burst while producer 1 requests -> grant unchanged, buf_write_valid=0, producer 1 is not granted until the owner's last.
- rst pulsed asynchronously, between clock edges, mid-burst -> grant=0, busy=0, burst_count=0 immediately; on release with all four requesting, producer 0 wins first.
